// File: rtl/sandpile_mem_arbiter_if.sv
// Bundle of pixel-counter, display, update-engine and cell-RAM signals around the
// sandpile RAM arbiter. The slave modport is the arbiter; master is everything else.
interface sandpile_mem_arbiter_if #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 2,
    parameter int UPD_BUDGET = 2048
);
    localparam int CNT_W = $clog2(UPD_BUDGET + 1);

    logic [9:0]        pixel_x;
    logic [9:0]        pixel_y;
    logic              done_x;
    logic              done_y;

    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_rdata;
    logic              disp_rvalid;

    logic              upd_req;
    logic              upd_we;
    logic [ADDR_W-1:0] upd_addr;
    logic [DATA_W-1:0] upd_wdata;
    logic              upd_gnt;
    logic [DATA_W-1:0] upd_rdata;
    logic              upd_rvalid;
    logic              upd_window;
    logic [CNT_W-1:0]  upd_count;
    logic              frame_start;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  pixel_x, pixel_y, done_x, done_y,
        input  disp_req, disp_addr,
        input  upd_req, upd_we, upd_addr, upd_wdata,
        input  mem_rdata,
        output disp_rdata, disp_rvalid,
        output upd_gnt, upd_rdata, upd_rvalid, upd_window, upd_count, frame_start,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output pixel_x, pixel_y, done_x, done_y,
        output disp_req, disp_addr,
        output upd_req, upd_we, upd_addr, upd_wdata,
        output mem_rdata,
        input  disp_rdata, disp_rvalid,
        input  upd_gnt, upd_rdata, upd_rvalid, upd_window, upd_count, frame_start,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sandpile_mem_arbiter.sv
// Single-port sandpile cell RAM arbiter: display reads always win, the update engine
// gets the RAM only during vertical blanking and only up to a per-frame access budget.
module sandpile_mem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 2,
    parameter int V_ACTIVE   = 480,
    parameter int UPD_BUDGET = 2048
) (
    input  logic                    clk,
    input  logic                    reset_n,
    sandpile_mem_arbiter_if.slave   bus
);
    localparam int               CNT_W         = $clog2(UPD_BUDGET + 1);
    localparam logic [9:0]       LAST_ACTIVE_Y = 10'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] BUDGET        = CNT_W'(UPD_BUDGET);
    localparam logic [CNT_W-1:0] BUDGET_M1     = CNT_W'(UPD_BUDGET - 1);

    typedef enum logic [1:0] {
        ST_ACTIVE    = 2'd0,
        ST_VBLANK    = 2'd1,
        ST_EXHAUSTED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_UPD  = 2'd2
    } tag_t;

    state_t           r_state;
    state_t           w_state_next;
    tag_t             r_tag;
    tag_t             w_tag_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             r_frame_start;

    logic             w_frame_end;
    logic             w_enter_vblank;
    logic             w_gnt;
    logic             w_budget_hit;
    logic             w_disp_sel;
    logic             w_unused;

    // Horizontal position is not needed; line/frame ends come from done_x/done_y.
    assign w_unused = ^bus.pixel_x;

    assign w_frame_end    = bus.done_x && bus.done_y;
    assign w_enter_vblank = bus.done_x && (bus.pixel_y == LAST_ACTIVE_Y);

    // Gating with reset_n keeps the RAM and the grant quiet while reset is held.
    assign w_disp_sel   = reset_n && bus.disp_req;
    assign w_gnt        = reset_n && (r_state == ST_VBLANK) && bus.upd_req && !bus.disp_req;
    assign w_budget_hit = w_gnt && (r_count == BUDGET_M1);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACTIVE: begin
                if (!w_frame_end && w_enter_vblank) begin
                    w_state_next = ST_VBLANK;
                end
            end
            ST_VBLANK: begin
                // End of frame wins over running out of budget in the same cycle.
                if (w_frame_end) begin
                    w_state_next = ST_ACTIVE;
                end else if (w_budget_hit) begin
                    w_state_next = ST_EXHAUSTED;
                end
            end
            ST_EXHAUSTED: begin
                if (w_frame_end) begin
                    w_state_next = ST_ACTIVE;
                end
            end
            default: w_state_next = ST_ACTIVE;
        endcase
    end

    always_comb begin
        w_count_next = r_count;
        if (w_frame_end) begin
            w_count_next = '0;
        end else if (w_gnt && (r_count != BUDGET)) begin
            w_count_next = r_count + 1'b1;
        end
    end

    always_comb begin
        w_tag_next = TAG_NONE;
        if (w_disp_sel) begin
            w_tag_next = TAG_DISP;
        end else if (w_gnt && !bus.upd_we) begin
            w_tag_next = TAG_UPD;
        end
    end

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (w_disp_sel) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.disp_addr;
        end else if (w_gnt) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.upd_we;
            bus.mem_addr  = bus.upd_addr;
            bus.mem_wdata = bus.upd_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_ACTIVE;
            r_tag         <= TAG_NONE;
            r_count       <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_tag         <= w_tag_next;
            r_count       <= w_count_next;
            r_frame_start <= w_frame_end;
        end
    end

    // RAM data lands one cycle after the access; the tag says whose read it was.
    assign bus.disp_rvalid = (r_tag == TAG_DISP);
    assign bus.upd_rvalid  = (r_tag == TAG_UPD);
    assign bus.disp_rdata  = bus.disp_rvalid ? bus.mem_rdata : '0;
    assign bus.upd_rdata   = bus.upd_rvalid  ? bus.mem_rdata : '0;

    assign bus.upd_gnt     = w_gnt;
    assign bus.upd_window  = (r_state == ST_VBLANK);
    assign bus.upd_count   = r_count;
    assign bus.frame_start = r_frame_start;
endmodule

// File: tb/tb_sandpile_mem_arbiter.sv
// Bench for sandpile_mem_arbiter: behavioural cell RAM, read scoreboard, vector table
// for the RAM mux, plus sequences for lockout, budget, rollover and reset mid-read.
module tb_sandpile_mem_arbiter;
    localparam int AW     = 12;
    localparam int DW     = 2;
    localparam int BUDGET = 4;

    logic clk;
    logic reset_n;

    sandpile_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .UPD_BUDGET(BUDGET)) bus ();

    sandpile_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .V_ACTIVE(480), .UPD_BUDGET(BUDGET)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        logic          is_upd;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    typedef struct {
        logic          d;
        logic          u;
        logic          we;
        logic [AW-1:0] da;
        logic [AW-1:0] ua;
        logic [DW-1:0] wd;
        logic          x_gnt;
        logic          x_en;
        logic          x_we;
        logic [AW-1:0] x_addr;
        logic [DW-1:0] x_wd;
    } vec_t;

    int            n_total = 0;
    int            n_bad   = 0;
    int            cyc     = 0;
    exp_t          sb[$];
    vec_t          tbl[6];
    logic [DW-1:0] ram[1 << AW];
    logic [DW-1:0] shadow[1 << AW];
    logic          ram_init = 1'b0;

    function automatic logic [DW-1:0] pat(input int a);
        logic [AW-1:0] v;
        v = AW'(a);
        return v[1:0] ^ v[5:4];
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Cell RAM: one-cycle synchronous read, preloaded on the first edge.
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= pat(i);
            ram_init <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    // Scoreboard side: every rvalid must match the oldest expected read.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                n_total++;
                n_bad++;
                $display("FAIL rvalid_missing: got none want %s rvalid data=%0d (cycle %0d)",
                         sb[0].is_upd ? "upd" : "disp", sb[0].data, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (bus.disp_rvalid || bus.upd_rvalid) begin
                n_total++;
                if (bus.disp_rvalid && bus.upd_rvalid) begin
                    n_bad++;
                    $display("FAIL rvalid_both: got disp=1 upd=1 want one rvalid");
                end else if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL rvalid_unexpected: got disp=%0b upd=%0b want none (cycle %0d)",
                             bus.disp_rvalid, bus.upd_rvalid, cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.is_upd !== bus.upd_rvalid || e.cyc != cyc ||
                        (e.is_upd ? bus.upd_rdata : bus.disp_rdata) !== e.data) begin
                        n_bad++;
                        $display("FAIL rdata: got upd=%0b data=%0d cyc=%0d want upd=%0b data=%0d cyc=%0d",
                                 bus.upd_rvalid, e.is_upd ? bus.upd_rdata : bus.disp_rdata, cyc,
                                 e.is_upd, e.data, e.cyc);
                    end else begin
                        $display("read ok: %s data=%0d cycle=%0d", e.is_upd ? "upd" : "disp", e.data, cyc);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end else begin
            $display("check ok: %s = 0x%0h", name, act);
        end
    endtask

    task automatic push_read(input logic is_upd, input logic [AW-1:0] a);
        exp_t e;
        e.is_upd = is_upd;
        e.data   = shadow[a];
        e.cyc    = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic idle();
        bus.disp_req = 1'b0;
        bus.upd_req  = 1'b0;
        bus.upd_we   = 1'b0;
        bus.done_x   = 1'b0;
        bus.done_y   = 1'b0;
    endtask

    task automatic enter_vblank();
        bus.pixel_y = 10'd479;
        bus.pixel_x = 10'd799;
        bus.done_x  = 1'b1;
        tick();
        bus.done_x  = 1'b0;
        bus.pixel_x = 10'd0;
        bus.pixel_y = 10'd490;
        chk("vblank_window", bus.upd_window, 1);
    endtask

    task automatic rollover();
        bus.pixel_x = 10'd799;
        bus.pixel_y = 10'd524;
        bus.done_x  = 1'b1;
        bus.done_y  = 1'b1;
        tick();
        bus.done_x  = 1'b0;
        bus.done_y  = 1'b0;
        bus.pixel_x = 10'd0;
        bus.pixel_y = 10'd0;
        chk("roll_frame_start", bus.frame_start, 1);
        chk("roll_count", bus.upd_count, 0);
        chk("roll_window", bus.upd_window, 0);
        tick();
        chk("roll_frame_start_low", bus.frame_start, 0);
    endtask

    initial begin
        int viol;
        int grants;

        //         d     u     we    da      ua      wd    gnt   en    we    addr    wd
        tbl[0] = '{1'b0, 1'b0, 1'b0, 12'h3FF, 12'h155, 2'd1, 1'b0, 1'b0, 1'b0, 12'h000, 2'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 12'h0AB, 12'h155, 2'd1, 1'b0, 1'b1, 1'b0, 12'h0AB, 2'd0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 12'h0AC, 12'h156, 2'd3, 1'b0, 1'b1, 1'b0, 12'h0AC, 2'd0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 12'h0AD, 12'h200, 2'd0, 1'b1, 1'b1, 1'b0, 12'h200, 2'd0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 12'h0AE, 12'h201, 2'd3, 1'b1, 1'b1, 1'b1, 12'h201, 2'd3};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 12'h201, 12'h202, 2'd0, 1'b0, 1'b1, 1'b0, 12'h201, 2'd0};

        for (int i = 0; i < (1 << AW); i++) shadow[i] = pat(i);

        // Reset with both requesters asserted: RAM and grant must stay quiet.
        reset_n        = 1'b0;
        bus.pixel_x    = '0;
        bus.pixel_y    = '0;
        bus.done_x     = 1'b0;
        bus.done_y     = 1'b0;
        bus.disp_addr  = 12'h010;
        bus.upd_addr   = 12'h020;
        bus.upd_wdata  = 2'd3;
        bus.disp_req   = 1'b1;
        bus.upd_req    = 1'b1;
        bus.upd_we     = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_upd_gnt", bus.upd_gnt, 0);
        chk("rst_window", bus.upd_window, 0);
        chk("rst_count", bus.upd_count, 0);
        chk("rst_frame_start", bus.frame_start, 0);
        chk("rst_rvalids", {bus.disp_rvalid, bus.upd_rvalid}, 0);
        chk("rst_rdata", {bus.disp_rdata, bus.upd_rdata}, 0);
        tick();
        idle();
        reset_n = 1'b1;
        tick();

        // Active region: a held update request for a whole line gets nothing.
        bus.pixel_y   = 10'd100;
        bus.upd_req   = 1'b1;
        bus.upd_we    = 1'b1;
        bus.upd_addr  = 12'h123;
        bus.upd_wdata = 2'd1;
        viol = 0;
        for (int x = 0; x < 800; x++) begin
            bus.pixel_x = 10'(x);
            bus.done_x  = (x == 799);
            #1;
            if (bus.upd_gnt !== 1'b0 || bus.mem_we !== 1'b0) viol++;
            tick();
        end
        idle();
        chk("lockout_violations", viol, 0);
        chk("lockout_count", bus.upd_count, 0);
        chk("lockout_window", bus.upd_window, 0);

        // Window opens the cycle after the last active line ends.
        bus.pixel_y = 10'd479;
        bus.pixel_x = 10'd799;
        bus.done_x  = 1'b1;
        #1;
        chk("window_before", bus.upd_window, 0);
        tick();
        bus.done_x  = 1'b0;
        bus.pixel_x = 10'd0;
        bus.pixel_y = 10'd490;
        chk("window_after", bus.upd_window, 1);

        // Blank-window write 0x123 <= 2, then read it back.
        bus.upd_req   = 1'b1;
        bus.upd_we    = 1'b1;
        bus.upd_addr  = 12'h123;
        bus.upd_wdata = 2'd2;
        #1;
        chk("wr_gnt", bus.upd_gnt, 1);
        chk("wr_mem_we", bus.mem_we, 1);
        chk("wr_mem_addr", bus.mem_addr, 12'h123);
        shadow[12'h123] = 2'd2;
        tick();
        bus.upd_we = 1'b0;
        #1;
        chk("rd_gnt", bus.upd_gnt, 1);
        chk("rd_mem_we", bus.mem_we, 0);
        push_read(1'b1, 12'h123);
        tick();

        // Collision: display wins, update gets the first free cycle.
        bus.disp_req  = 1'b1;
        bus.disp_addr = 12'h050;
        bus.upd_addr  = 12'h060;
        #1;
        chk("col_gnt", bus.upd_gnt, 0);
        chk("col_mem_addr", bus.mem_addr, 12'h050);
        chk("col_mem_we", bus.mem_we, 0);
        push_read(1'b0, 12'h050);
        tick();
        bus.disp_req = 1'b0;
        #1;
        chk("col_gnt_after", bus.upd_gnt, 1);
        push_read(1'b1, 12'h060);
        tick();
        idle();
        tick();
        chk("col_count", bus.upd_count, 3);

        rollover();
        enter_vblank();

        // RAM mux vectors, applied back to back inside the window.
        for (int i = 0; i < 6; i++) begin
            bus.disp_req  = tbl[i].d;
            bus.upd_req   = tbl[i].u;
            bus.upd_we    = tbl[i].we;
            bus.disp_addr = tbl[i].da;
            bus.upd_addr  = tbl[i].ua;
            bus.upd_wdata = tbl[i].wd;
            #1;
            chk($sformatf("vec%0d_gnt", i), bus.upd_gnt, tbl[i].x_gnt);
            chk($sformatf("vec%0d_en", i), bus.mem_en, tbl[i].x_en);
            chk($sformatf("vec%0d_we", i), bus.mem_we, tbl[i].x_we);
            chk($sformatf("vec%0d_addr", i), bus.mem_addr, tbl[i].x_addr);
            if (tbl[i].x_we || !tbl[i].x_en) chk($sformatf("vec%0d_wdata", i), bus.mem_wdata, tbl[i].x_wd);
            if (tbl[i].x_en && tbl[i].x_we) shadow[tbl[i].x_addr] = tbl[i].x_wd;
            else if (tbl[i].x_en) push_read(tbl[i].x_gnt, tbl[i].x_addr);
            tick();
        end
        idle();
        tick();
        chk("tbl_count", bus.upd_count, 2);

        rollover();
        enter_vblank();

        // Budget: continuous requests, only BUDGET of them accepted.
        bus.upd_req   = 1'b1;
        bus.upd_we    = 1'b1;
        bus.upd_addr  = 12'h300;
        bus.upd_wdata = 2'd1;
        shadow[12'h300] = 2'd1;
        grants = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (bus.upd_gnt === 1'b1) grants++;
            tick();
        end
        idle();
        chk("budget_grants", grants, BUDGET);
        chk("budget_count", bus.upd_count, BUDGET);
        chk("budget_window", bus.upd_window, 0);
        bus.disp_req  = 1'b1;
        bus.disp_addr = 12'h300;
        push_read(1'b0, 12'h300);
        tick();
        idle();
        tick();

        rollover();
        enter_vblank();

        // Reset lands while an accepted update read is outstanding.
        bus.upd_req  = 1'b1;
        bus.upd_we   = 1'b0;
        bus.upd_addr = 12'h123;
        #1;
        chk("mr_gnt", bus.upd_gnt, 1);
        @(posedge clk);
        #2;
        reset_n      = 1'b0;
        bus.disp_req = 1'b1;
        #1;
        chk("mr_upd_rvalid", bus.upd_rvalid, 0);
        chk("mr_upd_rdata", bus.upd_rdata, 0);
        chk("mr_mem_en", bus.mem_en, 0);
        chk("mr_upd_gnt", bus.upd_gnt, 0);
        chk("mr_window", bus.upd_window, 0);
        chk("mr_count", bus.upd_count, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n      = 1'b1;
        bus.disp_req = 1'b0;
        #1;
        chk("mr_gnt_after_release", bus.upd_gnt, 0);
        chk("mr_window_after_release", bus.upd_window, 0);
        repeat (3) tick();
        chk("mr_no_rvalid", {bus.disp_rvalid, bus.upd_rvalid}, 0);
        idle();

        repeat (2) tick();
        chk("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/sandpile_mem_arbiter.md
# sandpile_mem_arbiter

Shares the single-port sandpile cell RAM between the VGA display fetch path and the sandpile update engine. Display reads always win. Update-engine accesses are granted only during vertical blanking, capped at a per-frame access budget. The block sits between the horizontal/vertical pixel counters, the display pipeline, the update engine and the cell RAM. It also emits the frame-start pulse that paces the update engine.

## Interface
- ADDR_W, 12, cell RAM address width (64x48 grid)
- DATA_W, 2, cell value width (sandpile heights 0-3)
- V_ACTIVE, 480, number of visible lines
- UPD_BUDGET, 2048, max accepted update-engine accesses per frame (≥1)

- clk  in  1  system/pixel clock
- reset_n  in  1  reset, asynchronous, active-low
- pixel_x  in  10  horizontal counter value
- pixel_y  in  10  vertical counter value
- done_x  in  1  high on last pixel of a line (x=799)
- done_y  in  1  high on last line of a frame (y=524)
- disp_req  in  1  display read request (no handshake, must be served)
- disp_addr  in  ADDR_W  display read address
- disp_rdata  out  DATA_W  display read data
- disp_rvalid  out  1  disp_rdata valid
- upd_req  in  1  update-engine access request
- upd_we  in  1  1=write, 0=read
- upd_addr  in  ADDR_W  update-engine address
- upd_wdata  in  DATA_W  update-engine write data
- upd_gnt  out  1  access accepted this cycle when upd_req&upd_gnt
- upd_rdata  out  DATA_W  update-engine read data
- upd_rvalid  out  1  upd_rdata valid
- upd_window  out  1  update window open (state VBLANK)
- upd_count  out  clog2(UPD_BUDGET+1)  accesses accepted this frame
- frame_start  out  1  one-cycle pulse, first cycle of a new frame
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, 1-cycle synchronous latency

## Operation
- States: ACTIVE (reset state), VBLANK, EXHAUSTED.
- ACTIVE→VBLANK: done_x && pixel_y==V_ACTIVE-1.
- VBLANK→EXHAUSTED: an accepted upd access makes upd_count reach UPD_BUDGET.
- VBLANK/EXHAUSTED→ACTIVE: done_x && done_y. Also clears upd_count to 0 and fires frame_start next cycle.
- done_x&&done_y takes precedence over the budget transition in the same cycle.
- upd_gnt = (state==VBLANK) && upd_req && !disp_req. Combinational, no registered grant.
- RAM mux:
  - disp_req: mem_en=1, mem_we=0, mem_addr=disp_addr. Display wins in every state.
  - Else, on upd grant: mem_en=1, mem_we=upd_we, mem_addr=upd_addr, mem_wdata=upd_wdata.
  - Else: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Read tag register records which requester issued the read (display / update / none). Next cycle, the tagged rvalid goes high and mem_rdata is forwarded to that port's rdata. Only one rvalid is ever high.
- Writes produce no rvalid.
- upd_count increments on every accepted upd access, read or write. It saturates at UPD_BUDGET.
- An ungranted upd_req must be held by the requester. The block keeps no request queue.

## Timing
- Read latency 1 cycle for both ports. Write completes in the accept cycle.
- frame_start is registered: high exactly in the cycle where the counters show (0,0).
- upd_window = (state==VBLANK), registered-state based. It goes high the cycle after the ACTIVE→VBLANK condition.
- Reset (async assert): state=ACTIVE, upd_count=0, read tag=none, frame_start=0, disp_rvalid=0, upd_rvalid=0, rdata outputs=0, upd_window=0.
- While reset_n=0, mem_en, mem_we and upd_gnt are forced 0.
- Reset mid-transaction: any outstanding read is dropped, with no rvalid after reset release.
- Reset release: the first frame_start occurs on the first done_x&&done_y seen.
- disp_req and an upd grant can never both drive the RAM in one cycle.

## Test plan
- Reset mid-read: upd read accepted, reset_n pulsed low before the next edge. Required: no rvalid after release; all outputs 0 during reset; state ACTIVE.
- Active-region lockout: pixel_y=100, upd_req=1 held for a full line. Required: upd_gnt=0 throughout, upd_count=0, mem_we never 1.
- Blank-window write then read: pixel_y=490, upd write addr 0x123 data 2, then upd read 0x123. Required: write with upd_gnt=1, mem_we=1 in the accept cycle; upd_rvalid=1 with upd_rdata=2 one cycle after the read accept.
- Priority collision: in VBLANK, disp_req=1 and upd_req=1 in the same cycle. Required: upd_gnt=0, mem_addr=disp_addr, disp_rvalid next cycle, upd_rvalid=0. Grant follows in the first cycle disp_req drops.
- Budget: UPD_BUDGET=4, continuous upd_req in VBLANK. Required: exactly 4 grants, upd_count=4, upd_window=0 afterwards.
- Frame rollover: drive done_x=done_y=1. Required: frame_start=1 for one cycle, upd_count=0, state ACTIVE.
